// File: rtl/seg7_pkg.sv
// Shared constants and types for the memory-mapped 8-digit seven-segment display.
// Digit registers sit at word addresses DIG_BASE..DIG_LAST.
package seg7_pkg;

  localparam logic [15:0] DIG_BASE   = 16'hF020;
  localparam logic [15:0] DIG_LAST   = 16'hF03C;
  localparam int          NUM_DIGITS = 8;

  typedef logic [4:0] digit_code_t;

  localparam digit_code_t CODE_BLANK = 5'h10;
  localparam digit_code_t CODE_DASH  = 5'h11;
  localparam digit_code_t CODE_H     = 5'h12;
  localparam digit_code_t CODE_L     = 5'h13;
  localparam digit_code_t CODE_P     = 5'h14;

  function automatic logic addr_in_range(input logic [15:0] addr);
    return (addr >= DIG_BASE) && (addr <= DIG_LAST);
  endfunction

endpackage

// File: rtl/seg7_display_if.sv
// Single-cycle CPU bus port of the display: the decoder-qualified write and a combinational read.
interface seg7_display_if;
  import seg7_pkg::*;

  logic [15:0] addr;
  logic        wen;
  digit_code_t wdata;
  logic [3:0]  rdata;

  modport master (output addr, output wen, output wdata, input rdata);
  modport slave  (input addr, input wen, input wdata, output rdata);

endinterface

// File: rtl/seg7_decode.sv
// Maps a 5-bit digit code to active-low segments {dp,g,f,e,d,c,b,a}.
// The decimal point is never lit.
module seg7_decode
  import seg7_pkg::*;
(
  input  digit_code_t code,
  output logic [7:0]  seg
);

  // Glyph lookup; 'b' and 'd' are lowercase so they stay distinct from '8' and '0'.
  always_comb begin
    seg = 8'hFF;
    case (code)
      5'h00:      seg = 8'hC0;
      5'h01:      seg = 8'hF9;
      5'h02:      seg = 8'hA4;
      5'h03:      seg = 8'hB0;
      5'h04:      seg = 8'h99;
      5'h05:      seg = 8'h92;
      5'h06:      seg = 8'h82;
      5'h07:      seg = 8'hF8;
      5'h08:      seg = 8'h80;
      5'h09:      seg = 8'h90;
      5'h0A:      seg = 8'h88;
      5'h0B:      seg = 8'h83;
      5'h0C:      seg = 8'hC6;
      5'h0D:      seg = 8'hA1;
      5'h0E:      seg = 8'h86;
      5'h0F:      seg = 8'h8E;
      CODE_BLANK: seg = 8'hFF;
      CODE_DASH:  seg = 8'hBF;
      CODE_H:     seg = 8'h89;
      CODE_L:     seg = 8'hC7;
      CODE_P:     seg = 8'h8C;
      default:    seg = 8'hFF;
    endcase
  end

endmodule

// File: rtl/seg7_display.sv
// Eight-digit multiplexed seven-segment display controller with a memory-mapped
// digit register file; each digit is lit for SCAN_DIV clocks in turn.
module seg7_display
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic           clk,
  input  logic           rst,
  seg7_display_if.slave  bus,
  output logic [7:0]     dig_an,
  output logic [7:0]     dig_seg
);

  localparam int              CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  digit_code_t      digit_r [NUM_DIGITS];
  logic [CNT_W-1:0] scan_cnt_r;
  logic [2:0]       scan_idx_r;
  logic [7:0]       dig_an_r;
  logic [7:0]       dig_seg_r;

  logic             addr_hit_s;
  logic             wr_en_s;
  logic [2:0]       bus_idx_s;
  logic [3:0]       rdata_s;
  digit_code_t      scan_code_s;
  logic [7:0]       seg_s;
  logic [7:0]       an_s;

  // Address decode and read mux; reads see the register before any same-cycle write lands.
  always_comb begin
    addr_hit_s = addr_in_range(bus.addr);
    bus_idx_s  = bus.addr[4:2];
    wr_en_s    = bus.wen && addr_hit_s && (bus.addr[1:0] == 2'b00);
    if (addr_hit_s) begin
      rdata_s = digit_r[bus_idx_s][3:0];
    end else begin
      rdata_s = 4'h0;
    end
  end

  assign bus.rdata = rdata_s;

  // Digit register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_r[i] <= CODE_BLANK;
      end
    end else if (wr_en_s) begin
      digit_r[bus_idx_s] <= bus.wdata;
    end
  end

  // Dwell counter and digit-select index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_r <= '0;
      scan_idx_r <= 3'd0;
    end else if (scan_cnt_r == CNT_LAST) begin
      scan_cnt_r <= '0;
      scan_idx_r <= scan_idx_r + 3'd1;
    end else begin
      scan_cnt_r <= scan_cnt_r + CNT_W'(1);
    end
  end

  // Only the digit currently scanned is decoded.
  always_comb begin
    scan_code_s = digit_r[scan_idx_r];
    an_s        = ~(8'h01 << scan_idx_r);
  end

  seg7_decode u_decode (
    .code (scan_code_s),
    .seg  (seg_s)
  );

  // Registered display drive; blanked with all anodes off while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_an_r  <= 8'hFF;
      dig_seg_r <= 8'hFF;
    end else begin
      dig_an_r  <= an_s;
      dig_seg_r <= seg_s;
    end
  end

  assign dig_an  = dig_an_r;
  assign dig_seg = dig_seg_r;

endmodule

// File: tb/tb_seg7_display.sv
// Directed self-checking bench for seg7_display with a short scan period.
module tb_seg7_display;
  import seg7_pkg::*;

  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] dig_an;
  logic [7:0] dig_seg;
  int         checks = 0;
  int         errors = 0;
  int         edge_n = 0;

  seg7_display_if bus();

  seg7_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .dig_an  (dig_an),
    .dig_seg (dig_seg)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; after edge n the displayed digit is ((n-1)/4)%8.
  always @(posedge clk or posedge rst) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  function automatic logic [7:0] glyph(input logic [4:0] c);
    case (c)
      5'h00: glyph = 8'hC0;  5'h01: glyph = 8'hF9;  5'h02: glyph = 8'hA4;  5'h03: glyph = 8'hB0;
      5'h04: glyph = 8'h99;  5'h05: glyph = 8'h92;  5'h06: glyph = 8'h82;  5'h07: glyph = 8'hF8;
      5'h08: glyph = 8'h80;  5'h09: glyph = 8'h90;  5'h0A: glyph = 8'h88;  5'h0B: glyph = 8'h83;
      5'h0C: glyph = 8'hC6;  5'h0D: glyph = 8'hA1;  5'h0E: glyph = 8'h86;  5'h0F: glyph = 8'h8E;
      5'h11: glyph = 8'hBF;  5'h12: glyph = 8'h89;  5'h13: glyph = 8'hC7;  5'h14: glyph = 8'h8C;
      default: glyph = 8'hFF;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.wen = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    bus.addr = 16'hF020; bus.wdata = 5'h08; bus.wen = 1'b1;
    tick();
    bus.wen = 1'b0;
    tick(); tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (dig_an !== 8'hFF) begin errors++; $display("FAIL reset_async_an: got %h expected %h", dig_an, 8'hFF); end
    checks++;
    if (dig_seg !== 8'hFF) begin errors++; $display("FAIL reset_async_seg: got %h expected %h", dig_seg, 8'hFF); end
    checks++;
    if (bus.rdata !== 4'h0) begin errors++; $display("FAIL reset_digit_blank: got %h expected %h", bus.rdata, 4'h0); end
    tick();
    checks++;
    if (dig_an !== 8'hFF) begin errors++; $display("FAIL reset_hold_an: got %h expected %h", dig_an, 8'hFF); end
    rst = 1'b0;
    tick();
    checks++;
    if (dig_an !== 8'hFE) begin errors++; $display("FAIL reset_release_an: got %h expected %h", dig_an, 8'hFE); end
    checks++;
    if (dig_seg !== 8'hFF) begin errors++; $display("FAIL reset_release_seg: got %h expected %h", dig_seg, 8'hFF); end
  endtask

  task automatic test_write_read();
    apply_reset();
    bus.addr = 16'hF024; bus.wdata = 5'h0A; bus.wen = 1'b1;
    #1;
    checks++;
    if (bus.rdata !== 4'h0) begin errors++; $display("FAIL read_during_write: got %h expected %h", bus.rdata, 4'h0); end
    tick();
    bus.wen = 1'b0;
    #1;
    checks++;
    if (bus.rdata !== 4'hA) begin errors++; $display("FAIL read_f024: got %h expected %h", bus.rdata, 4'hA); end
    bus.addr = 16'hF040; #1;
    checks++;
    if (bus.rdata !== 4'h0) begin errors++; $display("FAIL read_f040: got %h expected %h", bus.rdata, 4'h0); end
    bus.addr = 16'hF03C; bus.wdata = 5'h1C; bus.wen = 1'b1;
    tick();
    bus.wen = 1'b0;
    #1;
    checks++;
    if (bus.rdata !== 4'hC) begin errors++; $display("FAIL read_f03c: got %h expected %h", bus.rdata, 4'hC); end
    bus.addr = 16'hF03D; #1;
    checks++;
    if (bus.rdata !== 4'h0) begin errors++; $display("FAIL read_f03d: got %h expected %h", bus.rdata, 4'h0); end
    bus.addr = 16'hF020; #1;
    checks++;
    if (bus.rdata !== 4'h0) begin errors++; $display("FAIL read_f020: got %h expected %h", bus.rdata, 4'h0); end
  endtask

  task automatic test_range_guard();
    logic [15:0] bad_addr [4];
    bad_addr = '{16'hF01C, 16'hF040, 16'hF022, 16'hF03E};
    for (int i = 0; i < 4; i++) begin
      bus.addr = bad_addr[i]; bus.wdata = 5'h07; bus.wen = 1'b1;
      tick();
    end
    bus.wen = 1'b0;
    bus.addr = 16'hF020; #1;
    checks++;
    if (bus.rdata !== 4'h0) begin errors++; $display("FAIL guard_digit0: got %h expected %h", bus.rdata, 4'h0); end
    bus.addr = 16'hF03C; #1;
    checks++;
    if (bus.rdata !== 4'hC) begin errors++; $display("FAIL guard_digit7: got %h expected %h", bus.rdata, 4'hC); end
    bus.addr = 16'hF024; #1;
    checks++;
    if (bus.rdata !== 4'hA) begin errors++; $display("FAIL guard_digit1: got %h expected %h", bus.rdata, 4'hA); end
  endtask

  task automatic test_scan();
    logic [7:0] exp_an;
    apply_reset();
    for (int n = 1; n <= 40; n++) begin
      tick();
      exp_an = ~(8'h01 << (((n - 1) / 4) % 8));
      checks++;
      if (dig_an !== exp_an) begin errors++; $display("FAIL scan_an edge %0d: got %h expected %h", n, dig_an, exp_an); end
      checks++;
      if (dig_seg !== 8'hFF) begin errors++; $display("FAIL scan_seg edge %0d: got %h expected %h", n, dig_seg, 8'hFF); end
    end
  endtask

  task automatic run_batch(input logic [4:0] codes [8]);
    int         d;
    logic [7:0] exp_an;
    logic [7:0] exp_seg;
    for (int i = 0; i < 8; i++) begin
      bus.addr = 16'hF020 + 16'(i * 4); bus.wdata = codes[i]; bus.wen = 1'b1;
      tick();
    end
    bus.wen = 1'b0;
    for (int k = 0; k < 32; k++) begin
      tick();
      d       = ((edge_n - 1) / 4) % 8;
      exp_an  = ~(8'h01 << d);
      exp_seg = glyph(codes[d]);
      checks++;
      if (dig_an !== exp_an) begin errors++; $display("FAIL decode_an digit %0d: got %h expected %h", d, dig_an, exp_an); end
      checks++;
      if (dig_seg !== exp_seg) begin errors++; $display("FAIL decode_seg code %h: got %h expected %h", codes[d], dig_seg, exp_seg); end
    end
  endtask

  task automatic test_decode();
    logic [4:0] codes [8];
    apply_reset();
    codes = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07};
    run_batch(codes);
    codes = '{5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h0F};
    run_batch(codes);
    codes = '{5'h11, 5'h10, 5'h12, 5'h13, 5'h14, 5'h15, 5'h1F, 5'h1A};
    run_batch(codes);
    codes = '{5'h1F, 5'h03, 5'h0B, 5'h0D, 5'h1E, 5'h16, 5'h09, 5'h00};
    run_batch(codes);
  endtask

  task automatic test_write_during_scan();
    int         n;
    int         d;
    logic [7:0] exp_an;
    apply_reset();
    for (int i = 0; i < 16 && !((edge_n % 4) == 1 && edge_n > 4); i++) tick();
    checks++;
    if (!((edge_n % 4) == 1 && edge_n > 4)) begin
      errors++; $display("FAIL scan_phase_wait: got edge %0d expected phase 1 past edge 4", edge_n);
    end
    n      = edge_n;
    d      = ((n + 1) / 4) % 8;
    exp_an = ~(8'h01 << d);
    bus.addr = 16'hF020 + 16'(d * 4); bus.wdata = 5'h03; bus.wen = 1'b1;
    tick();
    bus.wen = 1'b0;
    checks++;
    if (dig_seg !== 8'hFF) begin errors++; $display("FAIL wscan_write_edge: got %h expected %h", dig_seg, 8'hFF); end
    checks++;
    if (dig_an !== exp_an) begin errors++; $display("FAIL wscan_an: got %h expected %h", dig_an, exp_an); end
    tick();
    checks++;
    if (dig_seg !== 8'hB0) begin errors++; $display("FAIL wscan_plus1: got %h expected %h", dig_seg, 8'hB0); end
  endtask

  initial begin
    bus.addr  = 16'h0000;
    bus.wen   = 1'b0;
    bus.wdata = 5'h00;
    test_reset();
    test_write_read();
    test_range_guard();
    test_scan();
    test_decode();
    test_write_during_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_display.md
SEG7_DISPLAY -- requirements
Module: seg7_display

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000: number of clk cycles each digit is lit; legal range 2..2^20.
REQ-002 The block SHALL have port clk  input  1  system clock; all state SHALL be updated on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-004 The block SHALL have port addr  input  16  CPU byte address from the bus decoder.
REQ-005 The block SHALL have port wen  input  1  write enable, already qualified by the bus decoder for the 7-seg range.
REQ-006 The block SHALL have port wdata  input  5  digit code: 0x0-0xF is a hex digit, 0x10 and above is a special character.
REQ-007 The block SHALL have port rdata  output  4  low 4 bits of the addressed digit register.
REQ-008 The block SHALL have port dig_an  output  8  digit enables, active-low; bit i drives digit i, and digit 0 is the rightmost.
REQ-009 The block SHALL have port dig_seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.

Function
REQ-010 The block SHALL hold 8 digit registers of 5 bits each; the index SHALL be addr[4:2] for word addresses 0xF020..0xF03C.
REQ-011 A write SHALL occur when wen=1 and addr is within 0xF020..0xF03C and addr[1:0]=00; any other address SHALL be ignored, even when wen=1.
REQ-012 A write SHALL update the digit register at the rising edge where wen=1; there SHALL be no other write latency.
REQ-013 rdata SHALL be combinational: the addressed register[3:0] when addr is in range, otherwise 4'h0.
REQ-014 rdata on a same-cycle read-during-write SHALL return the old value.
REQ-015 The block SHALL run a scan counter 0..SCAN_DIV-1; at terminal count the counter SHALL wrap to 0 and the scan index SHALL advance.
REQ-016 The scan index SHALL count 0..7 and wrap from 7 to 0.
REQ-017 dig_an and dig_seg SHALL be registered, updated every cycle from the current scan index and that digit's register, giving 1 cycle of latency.
REQ-018 After a digit write, the new value SHALL appear on dig_seg 1 cycle after the write edge if that digit is currently scanned.
REQ-019 dig_an SHALL have exactly one bit low at any time outside reset.
REQ-020 Hex codes 0x0-0xF SHALL drive the standard a-g glyphs, with 'b' and 'd' in lowercase.
REQ-021 Special codes SHALL decode as: 0x10 blank, 0x11 '-' (g only), 0x12 'H', 0x13 'L', 0x14 'P'; codes 0x15-0x1F SHALL be blank.
REQ-022 dp SHALL always be off (1).
REQ-023 The block SHALL contain no handshake; the bus access SHALL be single-cycle and never stall.

Reset
REQ-024 While rst=1, all digit registers SHALL be 0x10 (blank).
REQ-025 While rst=1, the scan counter and scan index SHALL be 0.
REQ-026 While rst=1, dig_an SHALL be 8'hFF and dig_seg SHALL be 8'hFF.
REQ-027 Asserting rst mid-scan SHALL force the reset state immediately, without waiting for a clock edge.
REQ-028 After rst deasserts, the first clock edge SHALL light digit 0 (dig_an=8'hFE) showing blank.

Structure
REQ-029 A package seg7_pkg SHALL hold the following constants:
- DIG_BASE=16'hF020, DIG_LAST=16'hF03C, NUM_DIGITS=8;
- code constants CODE_BLANK, CODE_DASH, CODE_H, CODE_L, CODE_P;
- a typedef for the 5-bit digit code.
REQ-030 A combinational sub-module seg7_decode SHALL map a 5-bit code to the 8-bit active-low segment pattern, instantiated once on the scanned digit.

Verification
REQ-031 Reset: assert rst mid-scan with SCAN_DIV=4 -> dig_an=FF and dig_seg=FF immediately; after release dig_an=FE and dig_seg=FF.
REQ-032 Write/read: write 0xA to 0xF024 -> rdata at 0xF024 = 4'hA on the next cycle; rdata at 0xF040 = 0.
REQ-033 Range guard: wen=1 at 0xF01C, 0xF040 and 0xF022 -> no digit register changes.
REQ-034 Scan: SCAN_DIV=4 -> dig_an steps FE,FD,...,7F at 4-cycle intervals, then wraps to FE.
REQ-035 Decode: write 0x8 to digit 0 -> seg 8'h80; write 0x11 -> 8'hBF; write 0x1F -> 8'hFF while digit 0 is scanned.
REQ-036 Write during scan: write 0x3 to the currently scanned digit -> dig_seg=8'hB0 exactly 1 cycle after the write edge.
